// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle MIPS-subset datapath: sequences fetch/decode/execute/
// memory/writeback, drives every datapath select and enable, and watches for stalled memory.
module multicycle_control #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [5:0] Opcode,
    input  logic       Zero,
    input  logic       Mem_ready,
    output logic       PC_write,
    output logic [1:0] PC_src,
    output logic       IorD,
    output logic       Mem_read,
    output logic       Mem_write,
    output logic       IR_write,
    output logic       Reg_dst,
    output logic       Mem_to_reg,
    output logic       Reg_write,
    output logic       ALU_src_A,
    output logic [1:0] ALU_src_B,
    output logic       ALU_op,
    output logic       Funct_sel,
    output logic [5:0] Funct_ovr,
    output logic [3:0] State,
    output logic       Fault,
    output logic [1:0] Fault_cause
);
    localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
    localparam logic [5:0] OP_BEQ = 6'b000100, OP_J = 6'b000010;
    localparam logic [5:0] F_ADD = 6'b100000, F_SUB = 6'b100010;
    localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW:0] TO = TIMEOUT_CYCLES[CW:0];

    typedef enum logic [3:0] {
        IDLE = 4'd0, FETCH = 4'd1, DECODE = 4'd2, MEM_ADDR = 4'd3, MEM_RD = 4'd4,
        WB_MEM = 4'd5, MEM_WR = 4'd6, EXEC_R = 4'd7, WB_R = 4'd8, BRANCH = 4'd9,
        JUMP = 4'd10, FAULT = 4'd15
    } state_t;

    state_t        state, state_n;
    logic [1:0]    cause_n;
    logic [CW-1:0] cnt;
    logic [CW:0]   cnt_inc;
    logic          waiting, timeout;

    // A stalled cycle times out when it would bring the count to TIMEOUT_CYCLES;
    // Mem_ready in that cycle wins because waiting is then false.
    assign waiting = (state == FETCH || state == MEM_RD || state == MEM_WR) && !Mem_ready;
    assign cnt_inc = {1'b0, cnt} + {{CW{1'b0}}, 1'b1};
    assign timeout = (TIMEOUT_CYCLES != 0) && waiting && (cnt_inc >= TO);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= IDLE;
            cnt         <= '0;
            Fault       <= 1'b0;
            Fault_cause <= 2'b00;
        end else begin
            state <= state_n;
            if (state_n != state)
                cnt <= '0;
            else if (waiting && cnt != '1)
                cnt <= cnt + CW'(1);
            if (state_n == FAULT && state != FAULT) begin
                Fault       <= 1'b1;
                Fault_cause <= cause_n;
            end
        end
    end

    always_comb begin
        state_n = state;
        cause_n = 2'b00;
        case (state)
            IDLE:     state_n = FETCH;
            FETCH:    if (Mem_ready) state_n = DECODE;
                      else if (timeout) begin state_n = FAULT; cause_n = 2'b10; end
            DECODE: begin
                case (Opcode)
                    OP_R:         state_n = EXEC_R;
                    OP_LW, OP_SW: state_n = MEM_ADDR;
                    OP_BEQ:       state_n = BRANCH;
                    OP_J:         state_n = JUMP;
                    default: begin state_n = FAULT; cause_n = 2'b01; end
                endcase
            end
            MEM_ADDR: state_n = (Opcode == OP_LW) ? MEM_RD : MEM_WR;
            MEM_RD:   if (Mem_ready) state_n = WB_MEM;
                      else if (timeout) begin state_n = FAULT; cause_n = 2'b10; end
            MEM_WR:   if (Mem_ready) state_n = FETCH;
                      else if (timeout) begin state_n = FAULT; cause_n = 2'b10; end
            WB_MEM, WB_R, BRANCH, JUMP: state_n = FETCH;
            EXEC_R:   state_n = WB_R;
            FAULT:    state_n = FAULT;
            default:  state_n = IDLE;
        endcase
    end

    always_comb begin
        PC_write = 1'b0; PC_src = 2'b00; IorD = 1'b0; Mem_read = 1'b0; Mem_write = 1'b0;
        IR_write = 1'b0; Reg_dst = 1'b0; Mem_to_reg = 1'b0; Reg_write = 1'b0;
        ALU_src_A = 1'b0; ALU_src_B = 2'b00; ALU_op = 1'b0; Funct_sel = 1'b0;
        Funct_ovr = 6'b000000;
        State = state;
        case (state)
            FETCH: begin
                Mem_read = 1'b1; ALU_src_B = 2'b01; ALU_op = 1'b1;
                Funct_sel = 1'b1; Funct_ovr = F_ADD;
                IR_write = Mem_ready; PC_write = Mem_ready;
            end
            DECODE: begin
                ALU_src_B = 2'b11; ALU_op = 1'b1; Funct_sel = 1'b1; Funct_ovr = F_ADD;
            end
            MEM_ADDR: begin
                ALU_src_A = 1'b1; ALU_src_B = 2'b10; ALU_op = 1'b1;
                Funct_sel = 1'b1; Funct_ovr = F_ADD;
            end
            MEM_RD:  begin IorD = 1'b1; Mem_read = 1'b1; end
            WB_MEM:  begin Reg_write = 1'b1; Mem_to_reg = 1'b1; end
            MEM_WR:  begin IorD = 1'b1; Mem_write = 1'b1; end
            EXEC_R:  begin ALU_src_A = 1'b1; ALU_op = 1'b1; end
            WB_R:    begin Reg_write = 1'b1; Reg_dst = 1'b1; end
            BRANCH: begin
                ALU_src_A = 1'b1; ALU_op = 1'b1; Funct_sel = 1'b1; Funct_ovr = F_SUB;
                PC_src = 2'b01; PC_write = Zero;
            end
            JUMP:    begin PC_src = 2'b10; PC_write = 1'b1; end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: each driven cycle queues the expected state and
// controls; a negedge monitor pops and compares against the DUT.
module tb_multicycle_control;
    localparam logic [5:0] R = 6'b000000, LW = 6'b100011, SW = 6'b101011;
    localparam logic [5:0] BEQ = 6'b000100, J = 6'b000010, BAD = 6'b111111;

    logic clk = 1'b0, reset_n = 1'b0, Zero = 1'b0, Mem_ready = 1'b0;
    logic [5:0] Opcode = 6'd0;
    logic PC_write, IorD, Mem_read, Mem_write, IR_write, Reg_dst, Mem_to_reg, Reg_write;
    logic ALU_src_A, ALU_op, Funct_sel, Fault;
    logic [1:0] PC_src, ALU_src_B, Fault_cause;
    logic [5:0] Funct_ovr;
    logic [3:0] State;
    logic [20:0] ctl;

    typedef struct { logic [3:0] st; logic [20:0] ctl; logic [2:0] fc; } item_t;
    item_t sb[$];
    int tests = 0, fails = 0;
    logic [2:0] exp_fc = 3'b000;
    logic [5:0] op = R;

    multicycle_control #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .reset_n(reset_n), .Opcode(Opcode), .Zero(Zero), .Mem_ready(Mem_ready),
        .PC_write(PC_write), .PC_src(PC_src), .IorD(IorD), .Mem_read(Mem_read),
        .Mem_write(Mem_write), .IR_write(IR_write), .Reg_dst(Reg_dst), .Mem_to_reg(Mem_to_reg),
        .Reg_write(Reg_write), .ALU_src_A(ALU_src_A), .ALU_src_B(ALU_src_B), .ALU_op(ALU_op),
        .Funct_sel(Funct_sel), .Funct_ovr(Funct_ovr), .State(State), .Fault(Fault),
        .Fault_cause(Fault_cause)
    );

    always #5 clk = ~clk;

    assign ctl = {PC_write, PC_src, IorD, Mem_read, Mem_write, IR_write, Reg_dst, Mem_to_reg,
                  Reg_write, ALU_src_A, ALU_src_B, ALU_op, Funct_sel, Funct_ovr};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [20:0] exp_ctl(input logic [3:0] st, input logic rdy, input logic z);
        logic pcw, iord, mrd, mwr, irw, rdst, m2r, rw, asa, aop, fsel;
        logic [1:0] pcs, asb;
        logic [5:0] fo;
        {pcw, iord, mrd, mwr, irw, rdst, m2r, rw, asa, aop, fsel} = '0;
        pcs = 2'b00; asb = 2'b00; fo = 6'b000000;
        case (st)
            4'd1:  begin mrd = 1; asb = 2'b01; aop = 1; fsel = 1; fo = 6'b100000; irw = rdy; pcw = rdy; end
            4'd2:  begin asb = 2'b11; aop = 1; fsel = 1; fo = 6'b100000; end
            4'd3:  begin asa = 1; asb = 2'b10; aop = 1; fsel = 1; fo = 6'b100000; end
            4'd4:  begin iord = 1; mrd = 1; end
            4'd5:  begin rw = 1; m2r = 1; end
            4'd6:  begin iord = 1; mwr = 1; end
            4'd7:  begin asa = 1; aop = 1; end
            4'd8:  begin rw = 1; rdst = 1; end
            4'd9:  begin asa = 1; aop = 1; fsel = 1; fo = 6'b100010; pcs = 2'b01; pcw = z; end
            4'd10: begin pcs = 2'b10; pcw = 1; end
            default: ;
        endcase
        return {pcw, pcs, iord, mrd, mwr, irw, rdst, m2r, rw, asa, asb, aop, fsel, fo};
    endfunction

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            item_t it;
            it = sb.pop_front();
            chk("state", {28'd0, State}, {28'd0, it.st});
            chk("ctl", {11'd0, ctl}, {11'd0, it.ctl});
            chk("fault", {29'd0, Fault, Fault_cause}, {29'd0, it.fc});
            chk("rw_excl", {31'd0, Mem_read & Mem_write}, 32'd0);
        end
    end

    // One clock: drive inputs, queue what the DUT must show this cycle, advance.
    task automatic c(input logic rdy, input logic z, input logic [3:0] st, input logic rn = 1'b1);
        item_t it;
        Opcode = op; Mem_ready = rdy; Zero = z; reset_n = rn;
        it.st = st; it.ctl = exp_ctl(st, rdy, z); it.fc = exp_fc;
        sb.push_back(it);
        @(posedge clk); #1;
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;

        // R-type, zero-wait memory: 0,1,2,7,8,1
        op = R;  c(1, 0, 0); c(1, 0, 1); c(1, 0, 2); c(1, 0, 7); c(1, 0, 8);
        // LW with three stall cycles in FETCH and in MEM_RD
        op = LW;
        repeat (3) c(0, 0, 1);
        c(1, 0, 1); c(1, 0, 2); c(1, 0, 3);
        repeat (3) c(0, 0, 4);
        c(1, 0, 4); c(1, 0, 5);
        // BEQ taken then not taken
        op = BEQ; c(1, 0, 1); c(1, 0, 2); c(1, 1, 9);
        c(1, 0, 1); c(1, 0, 2); c(1, 0, 9);
        // J
        op = J;  c(1, 0, 1); c(1, 0, 2); c(1, 0, 10);
        // SW zero-wait, then SW with Mem_ready on the 4th waiting cycle
        op = SW; c(1, 0, 1); c(1, 0, 2); c(1, 0, 3); c(1, 0, 6);
        c(1, 0, 1); c(1, 0, 2); c(1, 0, 3);
        repeat (3) c(0, 0, 6);
        c(1, 0, 6);
        // SW with Mem_ready held low: timeout fault after 4 waiting cycles
        c(1, 0, 1); c(1, 0, 2); c(1, 0, 3);
        repeat (4) c(0, 0, 6);
        exp_fc = 3'b110;
        for (int i = 0; i < 3; i++) c(1'($urandom), 1'($urandom), 15);
        c(1, 1, 15, 0);
        exp_fc = 3'b000;
        // Illegal opcode: fault held through random inputs, reset clears it
        op = BAD; c(1, 0, 0); c(1, 0, 1); c(1, 0, 2);
        exp_fc = 3'b101;
        for (int i = 0; i < 10; i++) c(1'($urandom), 1'($urandom), 15);
        c(0, 0, 15, 0);
        exp_fc = 3'b000;
        c(1, 0, 0);
        // Reset mid-MEM_WR wins over the pending write
        op = SW; c(1, 0, 1); c(1, 0, 2); c(1, 0, 3);
        c(0, 0, 6, 0);
        c(1, 0, 0); c(1, 0, 1);

        chk("sb_empty", sb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
